// File: rtl/fft_wb_stream_if.sv
// Bus bundle for fft_wb_stream: Wishbone slave in, Wishbone master out, and both FFT-core streams.
// slave = the block's view, master = the surrounding system's view.
interface fft_wb_stream_if #(
   parameter int DW = 16,
   parameter int IW = 11
);
   // Wishbone slave side (time-domain samples in)
   logic [2*DW-1:0] DAT_I;
   logic            WE_I;
   logic            STB_I;
   logic            CYC_I;
   logic            ACK_O;
   // Wishbone master side (frequency bins out)
   logic [2*DW-1:0] DAT_O;
   logic [IW-1:0]   IDX_O;
   logic            CYC_O;
   logic            STB_O;
   logic            WE_O;
   logic            ACK_I;
   // stream towards the FFT core
   logic [2*DW-1:0] core_dat_o;
   logic            core_val_o;
   logic            core_last_o;
   logic            core_rdy_i;
   // stream back from the FFT core
   logic [2*DW-1:0] core_dat_i;
   logic            core_val_i;
   logic            core_last_i;
   logic            core_rdy_o;

   modport slave (
      input  DAT_I, WE_I, STB_I, CYC_I, ACK_I,
      input  core_rdy_i, core_dat_i, core_val_i, core_last_i,
      output ACK_O, DAT_O, IDX_O, CYC_O, STB_O, WE_O,
      output core_dat_o, core_val_o, core_last_o, core_rdy_o
   );

   modport master (
      output DAT_I, WE_I, STB_I, CYC_I, ACK_I,
      output core_rdy_i, core_dat_i, core_val_i, core_last_i,
      input  ACK_O, DAT_O, IDX_O, CYC_O, STB_O, WE_O,
      input  core_dat_o, core_val_o, core_last_o, core_rdy_o
   );
endinterface

// File: rtl/fft_wb_stream.sv
// Wishbone front/back-end for a streaming FFT core: strips the cyclic prefix, feeds the core,
// and returns indexed bins through a FIFO. Define FFT_CP_REMOVE_EN to enable CP removal.
module fft_wb_stream #(
   parameter int DW          = 16,
   parameter int NFFT        = 2048,
   parameter int CP_LEN      = 256,
   parameter int OFIFO_DEPTH = 16,
   parameter int IW          = $clog2(NFFT)
) (
   input  logic           CLK_I,
   input  logic           RSTN_I,
   fft_wb_stream_if.slave bus,
   output logic [3:0]     FRM_CNT_O,
   output logic           ERR_O
);
`ifdef FFT_CP_REMOVE_EN
   localparam bit CP_EN = 1'b1;
`else
   localparam bit CP_EN = 1'b0;
`endif
   localparam int CP_E = CP_EN ? CP_LEN : 0;
   localparam int SYM  = CP_E + NFFT;
   localparam int ICW  = $clog2(SYM);
   localparam int AW   = $clog2(OFIFO_DEPTH);
   localparam int EW   = 1 + IW + 2*DW;

   // ---------------- input side ----------------
   logic [ICW-1:0] icnt;
   logic           in_cp;
   logic           in_last;
   logic           req;
   logic           acc;

   assign req     = bus.CYC_I & bus.STB_I & bus.WE_I;
   assign in_last = !in_cp && (icnt == ICW'(SYM-1));
   // CP samples are acked and dropped without waiting for the core
   assign acc     = in_cp ? req : (req & bus.core_rdy_i);

   assign bus.ACK_O       = acc;
   assign bus.core_val_o  = req & !in_cp;
   assign bus.core_last_o = in_last;
   assign bus.core_dat_o  = bus.DAT_I;

   // in_cp is a phase flag so a zero-length prefix needs no special compare
   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
         icnt  <= '0;
         in_cp <= (CP_E != 0);
      end else if (acc) begin
         if (in_last) begin
            icnt  <= '0;
            in_cp <= (CP_E != 0);
         end else begin
            icnt <= icnt + 1'b1;
            if (in_cp && (icnt == ICW'(CP_E-1)))
               in_cp <= 1'b0;
         end
      end
   end

   // ---------------- core output capture ----------------
   logic [IW-1:0] ocnt;
   logic          ocnt_end;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic [AW:0]   wptr;
   logic [AW:0]   rptr;
   logic [EW-1:0] mem [OFIFO_DEPTH];
   logic [EW-1:0] rd_ent;

   assign ocnt_end       = (ocnt == IW'(NFFT-1));
   assign full           = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign empty          = (wptr == rptr);
   assign push           = bus.core_val_i & !full;
   assign bus.core_rdy_o = !full;
   assign rd_ent         = mem[rptr[AW-1:0]];

   always_ff @(posedge CLK_I) begin
      if (push)
         mem[wptr[AW-1:0]] <= {bus.core_last_i, ocnt, bus.core_dat_i};
   end

   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   // an early last resyncs the bin counter so the next frame starts at bin 0
   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
         ocnt  <= '0;
         ERR_O <= 1'b0;
      end else if (push) begin
         ocnt <= (bus.core_last_i || ocnt_end) ? '0 : ocnt + 1'b1;
         if (bus.core_last_i != ocnt_end)
            ERR_O <= 1'b1;
      end
   end

   // ---------------- frame accounting ----------------
   logic inc;
   logic dec;

   assign inc = acc & in_last;
   assign dec = push & bus.core_last_i;

   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I)
         FRM_CNT_O <= '0;
      else if (inc && !dec && (FRM_CNT_O != 4'd15))
         FRM_CNT_O <= FRM_CNT_O + 4'd1;
      else if (dec && !inc && (FRM_CNT_O != 4'd0))
         FRM_CNT_O <= FRM_CNT_O - 4'd1;
   end

   // ---------------- Wishbone master output ----------------
   logic [2*DW-1:0] dat_q;
   logic [IW-1:0]   idx_q;
   logic            out_last;
   logic            stb;
   logic            cyc;
   logic            cyc_clr;

   assign pop = !empty & (!stb | bus.ACK_I);

   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
         stb      <= 1'b0;
         out_last <= 1'b0;
         dat_q    <= '0;
         idx_q    <= '0;
      end else if (pop) begin
         stb                       <= 1'b1;
         {out_last, idx_q, dat_q}  <= rd_ent;
      end else if (bus.ACK_I) begin
         stb <= 1'b0;
      end
   end

   // the cycle is only closed once the whole chain is idle after a frame's last bin
   assign cyc_clr = stb & bus.ACK_I & out_last & empty & !push
                  & (FRM_CNT_O == 4'd0) & !bus.CYC_I;

   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I)
         cyc <= 1'b0;
      else if (!empty)
         cyc <= 1'b1;
      else if (cyc_clr)
         cyc <= 1'b0;
   end

   assign bus.DAT_O = dat_q;
   assign bus.IDX_O = idx_q;
   assign bus.STB_O = stb;
   assign bus.WE_O  = stb;
   assign bus.CYC_O = cyc;
endmodule
